mul_long_unit: RTL and testbench
================================

# mul_long_unit

Iterative 32×32 multiplier in the execute stage, directly upstream of the register file's write port. It accepts MUL, UMULL and SMULL operations, computes the product over a fixed number of cycles, and presents a one-cycle write request. That request carries result_lo for write address a3 and, for long ops, result_hi for a4 together with the `long` qualifier. The controller stalls the pipeline while `busy` is high.

## Interface
- No parameters; operand width is fixed at 32, product width at 64.
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- op  input  2  00/01 MUL (low 32 bits only), 10 UMULL, 11 SMULL
- a  input  32  multiplicand (Rm)
- b  input  32  multiplier (Rs)
- rd_lo  input  4  destination for low word, captured at start
- rd_hi  input  4  destination for high word, captured at start
- busy  output  1  high from the cycle after start acceptance until done drops
- done  output  1  one-cycle pulse; doubles as register write enable
- long  output  1  high with done for UMULL/SMULL
- a3  output  4  captured rd_lo
- a4  output  4  captured rd_hi
- result_lo  output  32  product bits [31:0]
- result_hi  output  32  product bits [63:32]; 0 for MUL
- flag_n  output  1  MUL: result_lo[31]; long: result_hi[31]
- flag_z  output  1  MUL: result_lo==0; long: full 64-bit product == 0

## Operation
- FSM states: IDLE, RUN, FIX, DONE.
- IDLE -> RUN on start=1.
  - Capture op, a3, a4.
  - For SMULL, load the magnitudes |a| and |b|. Store sign = a[31]^b[31].
  - For other ops, load raw operands and set sign=0.
  - Clear the 64-bit accumulator and the 5-bit counter.
- RUN: radix-2 shift-add.
  - Each cycle, if multiplier LSB=1, add multiplicand to accumulator[63:32] with carry into a 65-bit sum.
  - Then shift the {carry, acc} pair right 1 and shift the multiplier right 1.
  - The counter increments; when counter==31, move to FIX.
- FIX: if sign=1, replace the product with its 64-bit two's complement. Then latch result_lo and result_hi.
  - For MUL, force result_hi=0; flags use the forced value.
  - Compute flags. Go to DONE.
- DONE: done=1, long = (op[1]==1). Go to IDLE.
- Magnitude of 0x80000000 is 0x80000000 as unsigned 32 bits; no overflow is possible.
- start in RUN/FIX/DONE is ignored, not queued.
- result_lo, result_hi, a3, a4 and the flags hold their values after DONE until the next FIX.
- op 01 behaves exactly as MUL.

## Timing
- Reset (any time, including mid-RUN):
  - State returns to IDLE immediately.
  - busy, done, long, a3, a4, result_lo, result_hi, flag_n, flag_z are all 0.
  - The in-flight operation is discarded and no done pulse is produced.
- Start accepted at edge T.
  - busy is high after edge T.
  - RUN occupies edges T+1..T+32; FIX is at edge T+33.
  - done, long and results are valid in the cycle after edge T+33. done drops after edge T+34.
- Latency start-edge -> done-visible is 33 cycles, independent of operands and op.
- busy=1 in RUN, FIX and DONE; busy=0 in IDLE.
- Back-to-back: start held high during DONE is ignored. The next acceptance is at the edge after DONE, when state is IDLE.
- The register file writes on the same edge that ends the DONE cycle; no combinational path exists from inputs to outputs.

## Test plan
- Reset: assert reset_n=0 mid-clock -> all outputs 0 at once, before any clock edge.
- MUL: a=7, b=6, rd_lo=2 -> 33 cycles later done=1, long=0, a3=2, result_lo=0x0000002A, result_hi=0, flag_n=0, flag_z=0.
- UMULL: a=b=0xFFFFFFFF -> result_hi=0xFFFFFFFE, result_lo=0x00000001, long=1, flag_n=1.
- SMULL, mixed signs: a=0xFFFFFFFE (-2), b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- SMULL, extremes:
  - a=b=0x80000000 -> hi=0x40000000, lo=0.
  - a=0, b=0x80000000 -> flag_z=1.
- Control:
  - Pulse start again at RUN cycle 5 with other operands -> ignored; the first result completes unchanged.
  - Pull reset_n low at RUN cycle 10 -> no done pulse; a following MUL 3×5 yields 15 at the normal latency.

Source files
------------

// File: rtl/mul_long_unit.sv
// Iterative 32x32 radix-2 shift-add multiplier for MUL / UMULL / SMULL.
// Produces a one-cycle register-file write request with the low/high product words and N/Z flags.
module mul_long_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  rd_lo,
    input  logic [3:0]  rd_hi,
    output logic        busy,
    output logic        done,
    output logic        long,
    output logic [3:0]  a3,
    output logic [3:0]  a4,
    output logic [31:0] result_lo,
    output logic [31:0] result_hi,
    output logic        flag_n,
    output logic        flag_z
);

    localparam int unsigned OP_W   = 32;
    localparam int unsigned PROD_W = 64;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned REG_W  = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [OP_W-1:0]     mcand_q, mcand_d;
    logic [OP_W-1:0]     mplier_q, mplier_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sign_q, sign_d;
    logic                long_op_q, long_op_d;
    logic [REG_W-1:0]    dst_lo_q, dst_lo_d;
    logic [REG_W-1:0]    dst_hi_q, dst_hi_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                long_q, long_d;
    logic [REG_W-1:0]    a3_q, a3_d;
    logic [REG_W-1:0]    a4_q, a4_d;
    logic [OP_W-1:0]     res_lo_q, res_lo_d;
    logic [OP_W-1:0]     res_hi_q, res_hi_d;
    logic                flag_n_q, flag_n_d;
    logic                flag_z_q, flag_z_d;

    logic [OP_W:0]       sum;
    logic [PROD_W-1:0]   prod;

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sign_d    = sign_q;
        long_op_d = long_op_q;
        dst_lo_d  = dst_lo_q;
        dst_hi_d  = dst_hi_q;
        a3_d      = a3_q;
        a4_d      = a4_q;
        res_lo_d  = res_lo_q;
        res_hi_d  = res_hi_q;
        flag_n_d  = flag_n_q;
        flag_z_d  = flag_z_q;

        sum  = {1'b0, acc_q[PROD_W-1:OP_W]} + (mplier_q[0] ? {1'b0, mcand_q} : (OP_W+1)'(0));
        prod = sign_q ? (~acc_q + PROD_W'(1)) : acc_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RUN;
                    long_op_d = op[1];
                    dst_lo_d  = rd_lo;
                    dst_hi_d  = rd_hi;
                    acc_d     = '0;
                    cnt_d     = '0;
                    if (op == 2'b11) begin
                        // Signed long: multiply magnitudes, re-apply sign in FIX.
                        mcand_d  = a[OP_W-1] ? (~a + OP_W'(1)) : a;
                        mplier_d = b[OP_W-1] ? (~b + OP_W'(1)) : b;
                        sign_d   = a[OP_W-1] ^ b[OP_W-1];
                    end else begin
                        mcand_d  = a;
                        mplier_d = b;
                        sign_d   = 1'b0;
                    end
                end
            end
            S_RUN: begin
                acc_d    = {sum, acc_q[OP_W-1:1]};
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(31)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                res_lo_d = prod[OP_W-1:0];
                a3_d     = dst_lo_q;
                a4_d     = dst_hi_q;
                if (long_op_q) begin
                    res_hi_d = prod[PROD_W-1:OP_W];
                    flag_n_d = prod[PROD_W-1];
                    flag_z_d = (prod == '0);
                end else begin
                    res_hi_d = '0;
                    flag_n_d = prod[OP_W-1];
                    flag_z_d = (prod[OP_W-1:0] == '0);
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
        long_d = (state_d == S_DONE) && long_op_q;
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            sign_q    <= 1'b0;
            long_op_q <= 1'b0;
            dst_lo_q  <= '0;
            dst_hi_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            long_q    <= 1'b0;
            a3_q      <= '0;
            a4_q      <= '0;
            res_lo_q  <= '0;
            res_hi_q  <= '0;
            flag_n_q  <= 1'b0;
            flag_z_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sign_q    <= sign_d;
            long_op_q <= long_op_d;
            dst_lo_q  <= dst_lo_d;
            dst_hi_q  <= dst_hi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            long_q    <= long_d;
            a3_q      <= a3_d;
            a4_q      <= a4_d;
            res_lo_q  <= res_lo_d;
            res_hi_q  <= res_hi_d;
            flag_n_q  <= flag_n_d;
            flag_z_q  <= flag_z_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign long      = long_q;
    assign a3        = a3_q;
    assign a4        = a4_q;
    assign result_lo = res_lo_q;
    assign result_hi = res_hi_q;
    assign flag_n    = flag_n_q;
    assign flag_z    = flag_z_q;

endmodule

// File: tb/tb_mul_long_unit.sv
// Self-checking bench for mul_long_unit: directed test-plan cases, random ops against
// an arithmetic reference model, start-ignore, mid-run reset and back-to-back issue.
module tb_mul_long_unit;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  rd_lo;
    logic [3:0]  rd_hi;
    logic        busy;
    logic        done;
    logic        long;
    logic [3:0]  a3;
    logic [3:0]  a4;
    logic [31:0] result_lo;
    logic [31:0] result_hi;
    logic        flag_n;
    logic        flag_z;

    int pass_cnt  = 0;
    int total_cnt = 0;

    localparam int LATENCY = 33;
    localparam int BUDGET  = 45;

    mul_long_unit dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .rd_lo     (rd_lo),
        .rd_hi     (rd_hi),
        .busy      (busy),
        .done      (done),
        .long      (long),
        .a3        (a3),
        .a4        (a4),
        .result_lo (result_lo),
        .result_hi (result_hi),
        .flag_n    (flag_n),
        .flag_z    (flag_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: product computed with plain 64-bit arithmetic.
    // Packed as {done, long, a3, a4, result_hi, result_lo, flag_n, flag_z}.
    function automatic logic [75:0] model(input logic [1:0] o, input logic [31:0] x,
                                          input logic [31:0] y, input logic [3:0] dl,
                                          input logic [3:0] dh);
        logic signed [63:0] sx, sy;
        logic [63:0] p;
        logic        lg, n, z;
        lg = o[1];
        if (o == 2'b11) begin
            sx = {{32{x[31]}}, x};
            sy = {{32{y[31]}}, y};
            p  = 64'(sx * sy);
        end else begin
            p = {32'd0, x} * {32'd0, y};
        end
        if (!lg) p[63:32] = 32'd0;
        n = lg ? p[63] : p[31];
        z = lg ? (p == 64'd0) : (p[31:0] == 32'd0);
        return {1'b1, lg, dl, dh, p[63:32], p[31:0], n, z};
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0001;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Drive a start at a negedge, let the next posedge accept it, drop start.
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [3:0] dl, input logic [3:0] dh);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y; rd_lo = dl; rd_hi = dh;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom; rd_lo = 4'($urandom); rd_hi = 4'($urandom);
    endtask

    // Count posedges after acceptance until done is seen, bounded.
    task automatic wait_done(input int l0, output int lat);
        lat = l0;
        while (done !== 1'b1 && lat < BUDGET) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0; rd_lo = '0; rd_hi = '0;
        #2;
        total_cnt++;
        if ({busy, done, long, a3, a4, result_lo, result_hi, flag_n, flag_z} !== '0)
            $display("FAIL reset_initial: outputs=%h required 0",
                     {busy, done, long, a3, a4, result_lo, result_hi, flag_n, flag_z});
        else pass_cnt++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({busy, done} !== 2'b00)
            $display("FAIL reset_idle: busy/done=%b required 00", {busy, done});
        else pass_cnt++;
    endtask

    task automatic test_directed;
        logic [1:0]  ops [7];
        logic [31:0] xs  [7];
        logic [31:0] ys  [7];
        logic [3:0]  dls [7];
        logic [3:0]  dhs [7];
        logic [75:0] exp_v [7];
        int lat;
        ops[0] = 2'b00; xs[0] = 32'd7;          ys[0] = 32'd6;          dls[0] = 4'd2;  dhs[0] = 4'd0;
        exp_v[0] = {1'b1, 1'b0, 4'd2, 4'd0, 32'h0000_0000, 32'h0000_002A, 1'b0, 1'b0};
        ops[1] = 2'b10; xs[1] = 32'hFFFF_FFFF; ys[1] = 32'hFFFF_FFFF; dls[1] = 4'd3;  dhs[1] = 4'd4;
        exp_v[1] = {1'b1, 1'b1, 4'd3, 4'd4, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1, 1'b0};
        ops[2] = 2'b11; xs[2] = 32'hFFFF_FFFE; ys[2] = 32'd3;          dls[2] = 4'd5;  dhs[2] = 4'd6;
        exp_v[2] = {1'b1, 1'b1, 4'd5, 4'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b1, 1'b0};
        ops[3] = 2'b11; xs[3] = 32'h8000_0000; ys[3] = 32'h8000_0000; dls[3] = 4'd7;  dhs[3] = 4'd8;
        exp_v[3] = {1'b1, 1'b1, 4'd7, 4'd8, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0};
        ops[4] = 2'b00; xs[4] = 32'h0001_0000; ys[4] = 32'h0001_0000; dls[4] = 4'd1;  dhs[4] = 4'd15;
        exp_v[4] = {1'b1, 1'b0, 4'd1, 4'd15, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1};
        ops[5] = 2'b01; xs[5] = 32'hFFFF_FFFF; ys[5] = 32'd2;          dls[5] = 4'd11; dhs[5] = 4'd12;
        exp_v[5] = {1'b1, 1'b0, 4'd11, 4'd12, 32'h0000_0000, 32'hFFFF_FFFE, 1'b1, 1'b0};
        ops[6] = 2'b11; xs[6] = 32'h0000_0000; ys[6] = 32'h8000_0000; dls[6] = 4'd9;  dhs[6] = 4'd10;
        exp_v[6] = {1'b1, 1'b1, 4'd9, 4'd10, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1};
        for (int i = 0; i < 7; i++) begin
            issue(ops[i], xs[i], ys[i], dls[i], dhs[i]);
            total_cnt++;
            if (busy !== 1'b1) $display("FAIL directed%0d_busy: busy=%b required 1", i, busy);
            else pass_cnt++;
            wait_done(0, lat);
            total_cnt++;
            if (lat !== LATENCY) $display("FAIL directed%0d_latency: got %0d required %0d", i, lat, LATENCY);
            else pass_cnt++;
            total_cnt++;
            if ({done, long, a3, a4, result_hi, result_lo, flag_n, flag_z} !== exp_v[i])
                $display("FAIL directed%0d_result: got %h required %h", i,
                         {done, long, a3, a4, result_hi, result_lo, flag_n, flag_z}, exp_v[i]);
            else pass_cnt++;
            @(negedge clk);
            total_cnt++;
            if ({busy, done, long} !== 3'b000 || {result_hi, result_lo} !== exp_v[i][65:2])
                $display("FAIL directed%0d_after: busy/done/long=%b res=%h required 000 res=%h", i,
                         {busy, done, long}, {result_hi, result_lo}, exp_v[i][65:2]);
            else pass_cnt++;
        end
    endtask

    task automatic test_async_reset;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        total_cnt++;
        if ({busy, done, long, a3, a4, result_lo, result_hi, flag_n, flag_z} !== '0)
            $display("FAIL async_reset: outputs=%h required 0",
                     {busy, done, long, a3, a4, result_lo, result_hi, flag_n, flag_z});
        else pass_cnt++;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_random;
        logic [1:0]  o;
        logic [31:0] x, y;
        logic [3:0]  dl, dh;
        logic [75:0] e;
        int lat;
        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom); x = pick_operand(); y = pick_operand();
            dl = 4'($urandom); dh = 4'($urandom);
            e = model(o, x, y, dl, dh);
            issue(o, x, y, dl, dh);
            wait_done(0, lat);
            total_cnt++;
            if (lat !== LATENCY || {done, long, a3, a4, result_hi, result_lo, flag_n, flag_z} !== e)
                $display("FAIL random%0d op=%b a=%h b=%h: lat=%0d got %h required lat=%0d %h", i, o, x, y,
                         lat, {done, long, a3, a4, result_hi, result_lo, flag_n, flag_z}, LATENCY, e);
            else pass_cnt++;
        end
    endtask

    task automatic test_start_ignored;
        logic [75:0] e;
        int lat;
        e = model(2'b11, 32'hFFFF_FF85, 32'h0001_2345, 4'd13, 4'd14);
        issue(2'b11, 32'hFFFF_FF85, 32'h0001_2345, 4'd13, 4'd14);
        repeat (4) @(negedge clk);
        start = 1'b1; op = 2'b10; a = 32'h1234_5678; b = 32'h9ABC_DEF0; rd_lo = 4'd1; rd_hi = 4'd2;
        @(negedge clk);
        start = 1'b0;
        wait_done(5, lat);
        total_cnt++;
        if (lat !== LATENCY || {done, long, a3, a4, result_hi, result_lo, flag_n, flag_z} !== e)
            $display("FAIL start_ignored: lat=%0d got %h required lat=%0d %h", lat,
                     {done, long, a3, a4, result_hi, result_lo, flag_n, flag_z}, LATENCY, e);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL start_ignored_idle: busy=%b required 0", busy);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_run;
        int dones;
        int lat;
        issue(2'b10, 32'hDEAD_BEEF, 32'h0BAD_F00D, 4'd4, 4'd5);
        repeat (10) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        total_cnt++;
        if ({busy, done} !== 2'b00) $display("FAIL reset_mid_run: busy/done=%b required 00", {busy, done});
        else pass_cnt++;
        @(negedge clk);
        reset_n = 1'b1;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) dones++;
        end
        total_cnt++;
        if (dones !== 0) $display("FAIL reset_discard: busy/done seen %0d times required 0", dones);
        else pass_cnt++;
        issue(2'b00, 32'd3, 32'd5, 4'd6, 4'd7);
        wait_done(0, lat);
        total_cnt++;
        if (lat !== LATENCY || {done, long, a3, result_hi, result_lo} !== {1'b1, 1'b0, 4'd6, 32'd0, 32'd15})
            $display("FAIL after_reset_mul: lat=%0d done=%b long=%b a3=%0d hi=%h lo=%h required lat=%0d 1 0 6 0 f",
                     lat, done, long, a3, result_hi, result_lo, LATENCY);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        logic [75:0] e;
        int lat;
        e = model(2'b10, 32'h0000_FFFF, 32'hFFFF_0000, 4'd3, 4'd9);
        issue(2'b00, 32'd100, 32'd200, 4'd1, 4'd2);
        wait_done(0, lat);
        start = 1'b1; op = 2'b10; a = 32'h0000_FFFF; b = 32'hFFFF_0000; rd_lo = 4'd3; rd_hi = 4'd9;
        @(negedge clk);
        total_cnt++;
        if ({busy, done} !== 2'b00) $display("FAIL b2b_gap: busy/done=%b required 00", {busy, done});
        else pass_cnt++;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL b2b_accept: busy=%b required 1", busy);
        else pass_cnt++;
        wait_done(0, lat);
        total_cnt++;
        if (lat !== LATENCY || {done, long, a3, a4, result_hi, result_lo, flag_n, flag_z} !== e)
            $display("FAIL b2b_result: lat=%0d got %h required lat=%0d %h", lat,
                     {done, long, a3, a4, result_hi, result_lo, flag_n, flag_z}, LATENCY, e);
        else pass_cnt++;
    endtask

    initial begin
        test_reset;
        test_directed;
        test_async_reset;
        test_random;
        test_start_ignored;
        test_reset_mid_run;
        test_back_to_back;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
